// File: rtl/rr_arb4_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_arb4_pkg
// Purpose  : Shared types and constants for the four-lane round-robin arbiter.
// Contents : state_t {IDLE, GRANT}, NUM_LANES, ID_W
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package rr_arb4_pkg;

  localparam int NUM_LANES = 4;
  localparam int ID_W      = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : rr_arb4_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_pick4
// Purpose  : Combinational rotating-priority encoder. The lane after ptr has
//            the highest priority; ptr itself has the lowest.
// Ports    : req    in  4  request vector
//            ptr    in  2  last winner
//            any    out 1  at least one request present
//            winner out 2  selected lane (0 when any=0)
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic                 any,
  output logic [ID_W-1:0]      winner
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    any     = |req;
    winner  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    // Offsets 1..4 wrap mod 4, so offset 4 revisits ptr last.
    for (int i = 1; i <= NUM_LANES; i++) begin
      w_idx = ptr + ID_W'(i);
      if (!w_found && req[w_idx]) begin
        winner  = w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_arb4
// Purpose  : Four-requester round-robin arbiter with bounded hold time.
//            Registered one-hot grant, encoded winner and expiry pulse.
// Ports    : clk       in  1  clock, rising edge
//            rst       in  1  synchronous active-high reset
//            req       in  4  per-lane level request
//            done      in  4  per-lane release pulse (holder bit only)
//            gnt       out 4  one-hot grant, zero when idle
//            gnt_valid out 1  OR of gnt
//            gnt_id    out 2  encoded winner, holds last value when idle
//            timeout   out 1  one-cycle pulse on MAX_HOLD revocation
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] req,
  input  logic [NUM_LANES-1:0] done,
  output logic [NUM_LANES-1:0] gnt,
  output logic                 gnt_valid,
  output logic [ID_W-1:0]      gnt_id,
  output logic                 timeout
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t               r_state,   w_state_nxt;
  logic [ID_W-1:0]      r_ptr,     w_ptr_nxt;
  logic [CNT_W-1:0]     r_cnt,     w_cnt_nxt;
  logic [NUM_LANES-1:0] r_gnt,     w_gnt_nxt;
  logic [ID_W-1:0]      r_gnt_id,  w_gnt_id_nxt;
  logic                 r_valid;
  logic                 r_timeout, w_timeout_nxt;

  logic                 w_any;
  logic [ID_W-1:0]      w_winner;
  logic                 w_hold_done;
  logic                 w_hold_req;
  logic                 w_expire;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .any    (w_any),
    .winner (w_winner)
  );

  assign w_hold_done = done[r_gnt_id];
  assign w_hold_req  = req[r_gnt_id];
  assign w_expire    = (r_cnt == C_CNT_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt  = GRANT;
          w_gnt_nxt    = NUM_LANES'(1) << w_winner;
          w_gnt_id_nxt = w_winner;
          w_ptr_nxt    = w_winner;
          w_cnt_nxt    = '0;
        end
      end
      GRANT: begin
        if (w_hold_done || !w_hold_req || w_expire) begin
          w_state_nxt   = IDLE;
          w_gnt_nxt     = '0;
          // A normal release or withdrawal wins over a coincident expiry.
          w_timeout_nxt = w_expire && w_hold_req && !w_hold_done;
        end else begin
          // Not expired here, so cnt+1 never exceeds MAX_HOLD-1.
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= ID_W'(NUM_LANES - 1);
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_valid   <= |w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_id    = r_gnt_id;
  assign timeout   = r_timeout;

endmodule : rr_arb4
`default_nettype wire

// File: tb/tb_rr_arb4.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_rr_arb4
// Purpose  : Self-checking bench for rr_arb4 with MAX_HOLD=4 and MAX_HOLD=1
//            instances driven by the same stimulus, each compared against a
//            lane/holder reference model.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_rr_arb4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;

  logic [3:0] gnt4, gnt1;
  logic       val4, val1;
  logic [1:0] id4,  id1;
  logic       to4,  to1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, index 0 -> MAX_HOLD=4, index 1 -> MAX_HOLD=1.
  int hmax   [2] = '{4, 1};
  int holder [2];   // granted lane, -1 when idle
  int held   [2];   // cycles the current holder has been granted
  int last   [2];   // most recent winner (lowest priority next round)
  int lastid [2];
  int tout   [2];

  always #5 clk = ~clk;

  rr_arb4 #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt4), .gnt_valid(val4), .gnt_id(id4), .timeout(to4)
  );

  rr_arb4 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt1), .gnt_valid(val1), .gnt_id(id1), .timeout(to1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int m, input logic [3:0] r, input logic [3:0] d, input logic rs);
    int lane;
    if (rs) begin
      holder[m] = -1; held[m] = 0; last[m] = 3; lastid[m] = 0; tout[m] = 0;
    end else if (holder[m] < 0) begin
      tout[m] = 0;
      for (int k = 1; k <= 4; k++) begin
        lane = (last[m] + k) % 4;
        if (holder[m] < 0 && r[lane]) begin
          holder[m] = lane; last[m] = lane; lastid[m] = lane; held[m] = 1;
        end
      end
    end else begin
      lane = holder[m];
      if (d[lane] || !r[lane]) begin
        holder[m] = -1; tout[m] = 0;
      end else if (held[m] >= hmax[m]) begin
        holder[m] = -1; tout[m] = 1;
      end else begin
        held[m]++; tout[m] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = (holder[0] >= 0) ? 4'(1 << holder[0]) : 4'h0;
    check("h4_gnt",     {4'h0, gnt4}, {4'h0, eg});
    check("h4_valid",   {7'h0, val4}, {7'h0, (holder[0] >= 0)});
    check("h4_id",      {6'h0, id4},  8'(lastid[0]));
    check("h4_timeout", {7'h0, to4},  8'(tout[0]));
    eg = (holder[1] >= 0) ? 4'(1 << holder[1]) : 4'h0;
    check("h1_gnt",     {4'h0, gnt1}, {4'h0, eg});
    check("h1_valid",   {7'h0, val1}, {7'h0, (holder[1] >= 0)});
    check("h1_id",      {6'h0, id1},  8'(lastid[1]));
    check("h1_timeout", {7'h0, to1},  8'(tout[1]));
  endtask

  // Apply inputs for one cycle, advance the model on the edge, check after.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_edge(0, r, d, rs);
    model_edge(1, r, d, rs);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] rr;
    logic [3:0] dd;
    logic       rs;

    // Reset state
    step(4'h0, 4'h0, 1'b1);
    step(4'h0, 4'h0, 1'b1);

    // All lanes requesting, no done: rotation 0,1,2,3,0 with expiry
    for (int i = 0; i < 27; i++) step(4'hF, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);

    // Lane 2 alone, done on the 3rd grant cycle
    step(4'h4, 4'h0, 1'b0);
    step(4'h4, 4'h0, 1'b0);
    step(4'h4, 4'h0, 1'b0);
    step(4'h4, 4'h4, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);

    // Lane 1 holds; foreign done ignored; withdrawal releases without timeout
    step(4'h2, 4'h0, 1'b0);
    step(4'h2, 4'h8, 1'b0);
    step(4'h2, 4'h8, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);

    // done coincides with the last allowed hold cycle
    step(4'h1, 4'h0, 1'b0);
    step(4'h1, 4'h0, 1'b0);
    step(4'h1, 4'h0, 1'b0);
    step(4'h1, 4'h0, 1'b0);
    step(4'h1, 4'h1, 1'b0);
    step(4'h0, 4'h0, 1'b0);

    // Reset mid-grant, then lanes 1 and 3 compete with ptr back at 3
    step(4'h2, 4'h0, 1'b0);
    step(4'h2, 4'h0, 1'b0);
    step(4'h2, 4'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(4'hA, 4'h0, 1'b0);

    // Single persistent requester: alternating grant/idle on the 1-cycle instance
    for (int i = 0; i < 8; i++) step(4'h1, 4'h0, 1'b0);

    // Randomized traffic with persistent requests, sparse done and rare reset
    rr = 4'h0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) rr = rr ^ 4'($urandom_range(0, 15));
      dd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      rs = ($urandom_range(0, 99) == 0);
      step(rr, dd, rs);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rr_arb4
`default_nettype wire
